// File: rtl/reset_seq_pkg.sv
// Shared encodings and width helpers for the reset sequencer and its synchroniser.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_DONE    = 2'd2
  } seq_state_e;

  function automatic int clog2_min1(input int value);
    int w;
    w = $clog2(value);
    return (w < 32'sd1) ? 32'sd1 : w;
  endfunction

  function automatic int max_clog2(input int a, input int b);
    return clog2_min1((a > b) ? a : b);
  endfunction

endpackage

// File: rtl/reset_sync_chain.sv
// Reset synchroniser: clears asynchronously, releases after SYNC_STAGES clock edges.
module reset_sync_chain #(
  parameter int SYNC_STAGES = 4
) (
  input  logic i_clk,
  input  logic i_rst_n,
  output logic o_rst_sync
);

  logic [SYNC_STAGES-1:0] r_chain;

  // Shift ones in behind the async clear.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_chain <= {SYNC_STAGES{1'b0}};
    end else begin
      r_chain <= {r_chain[SYNC_STAGES-2:0], 1'b1};
    end
  end

  assign o_rst_sync = r_chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Multi-domain reset controller: hold for a minimum time, then release each
// domain in index order with fixed spacing, and report completion.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS = 4,
  parameter int SYNC_STAGES = 4,
  parameter int MIN_ASSERT  = 8,
  parameter int STAGE_DELAY = 16
) (
  input  logic                   clk_100m,
  input  logic                   rst_n,
  input  logic                   soft_rst_req,
  input  logic [NUM_DOMAINS-1:0] domain_en,
  output logic [NUM_DOMAINS-1:0] rst_n_out,
  output logic                   reset_done,
  output logic                   busy,
  output logic [1:0]             seq_state
);

  localparam int CNT_W = max_clog2(MIN_ASSERT, STAGE_DELAY);
  localparam int IDX_W = clog2_min1(NUM_DOMAINS);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(MIN_ASSERT - 1);
  localparam logic [CNT_W-1:0] STAGE_LAST = CNT_W'(STAGE_DELAY - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DOMAINS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(32'd1);
  localparam logic [IDX_W-1:0] IDX_ONE    = IDX_W'(32'd1);

  if (NUM_DOMAINS < 1) begin : g_bad_num_domains
    $error("reset_sequencer: NUM_DOMAINS must be >= 1");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync_stages
    $error("reset_sequencer: SYNC_STAGES must be >= 2");
  end
  if (MIN_ASSERT < 1) begin : g_bad_min_assert
    $error("reset_sequencer: MIN_ASSERT must be >= 1");
  end
  if (STAGE_DELAY < 1) begin : g_bad_stage_delay
    $error("reset_sequencer: STAGE_DELAY must be >= 1");
  end

  seq_state_e             r_state, w_next_state;
  logic [CNT_W-1:0]       r_cnt, w_next_cnt;
  logic [IDX_W-1:0]       r_idx, w_next_idx;
  logic [NUM_DOMAINS-1:0] r_rst_n_out, w_next_rst_n_out;
  logic                   r_done, w_next_done;
  logic                   r_busy;
  logic                   w_rst_sync;

  reset_sync_chain #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .i_clk      (clk_100m),
    .i_rst_n    (rst_n),
    .o_rst_sync (w_rst_sync)
  );

  // Next-state logic; a soft request overrides every transition, including a release slot.
  always_comb begin
    w_next_state     = r_state;
    w_next_cnt       = r_cnt;
    w_next_idx       = r_idx;
    w_next_rst_n_out = r_rst_n_out;
    w_next_done      = r_done;
    if (soft_rst_req) begin
      w_next_state     = ST_HOLD;
      w_next_cnt       = {CNT_W{1'b0}};
      w_next_idx       = {IDX_W{1'b0}};
      w_next_rst_n_out = {NUM_DOMAINS{1'b0}};
      w_next_done      = 1'b0;
    end else if (w_rst_sync) begin
      case (r_state)
        ST_HOLD: begin
          if (r_cnt == HOLD_LAST) begin
            w_next_state = ST_RELEASE;
            w_next_cnt   = {CNT_W{1'b0}};
            w_next_idx   = {IDX_W{1'b0}};
          end else begin
            w_next_cnt = r_cnt + CNT_ONE;
          end
        end
        ST_RELEASE: begin
          for (int i = 0; i < NUM_DOMAINS; i++) begin
            if ((r_cnt == {CNT_W{1'b0}}) && (r_idx == IDX_W'(i))) begin
              w_next_rst_n_out[i] = domain_en[i];
            end else begin
              w_next_rst_n_out[i] = r_rst_n_out[i];
            end
          end
          if (r_cnt == STAGE_LAST) begin
            w_next_cnt = {CNT_W{1'b0}};
            if (r_idx == IDX_LAST) begin
              w_next_state = ST_DONE;
              w_next_done  = 1'b1;
            end else begin
              w_next_idx = r_idx + IDX_ONE;
            end
          end else begin
            w_next_cnt = r_cnt + CNT_ONE;
          end
        end
        ST_DONE: begin
          w_next_state = ST_DONE;
        end
        default: begin
          w_next_state     = ST_HOLD;
          w_next_cnt       = {CNT_W{1'b0}};
          w_next_idx       = {IDX_W{1'b0}};
          w_next_rst_n_out = {NUM_DOMAINS{1'b0}};
          w_next_done      = 1'b0;
        end
      endcase
    end else begin
      w_next_state = r_state;
    end
  end

  // State and output registers.
  always_ff @(posedge clk_100m or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_HOLD;
      r_cnt       <= {CNT_W{1'b0}};
      r_idx       <= {IDX_W{1'b0}};
      r_rst_n_out <= {NUM_DOMAINS{1'b0}};
      r_done      <= 1'b0;
      r_busy      <= 1'b1;
    end else begin
      r_state     <= w_next_state;
      r_cnt       <= w_next_cnt;
      r_idx       <= w_next_idx;
      r_rst_n_out <= w_next_rst_n_out;
      r_done      <= w_next_done;
      r_busy      <= (w_next_state != ST_DONE);
    end
  end

  assign rst_n_out  = r_rst_n_out;
  assign reset_done = r_done;
  assign busy       = r_busy;
  assign seq_state  = r_state;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench: expectations from a timing model are queued, then compared as edges arrive.
module tb_reset_sequencer;

  localparam int N   = 4;
  localparam int SYN = 4;
  localparam int MIN = 8;
  localparam int DLY = 16;

  logic         clk;
  logic         rst_n, soft_rst_req;
  logic [3:0]   domain_en;
  logic [3:0]   rst_n_out;
  logic         reset_done, busy;
  logic [1:0]   seq_state;

  logic         c_rst_n, c_soft, c_en;
  logic         c_out, c_done, c_busy;
  logic [1:0]   c_state;

  reset_sequencer #(.NUM_DOMAINS(N), .SYNC_STAGES(SYN), .MIN_ASSERT(MIN), .STAGE_DELAY(DLY)) u_dut (
    .clk_100m(clk), .rst_n(rst_n), .soft_rst_req(soft_rst_req), .domain_en(domain_en),
    .rst_n_out(rst_n_out), .reset_done(reset_done), .busy(busy), .seq_state(seq_state));

  reset_sequencer #(.NUM_DOMAINS(1), .SYNC_STAGES(2), .MIN_ASSERT(1), .STAGE_DELAY(1)) u_corner (
    .clk_100m(clk), .rst_n(c_rst_n), .soft_rst_req(c_soft), .domain_en(c_en),
    .rst_n_out(c_out), .reset_done(c_done), .busy(c_busy), .seq_state(c_state));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         edge_n;
    bit         corner;
    logic [7:0] exp;
  } item_t;

  item_t exp_q[$];
  string tag_q[$];
  int    ecount = 0;
  int    n_cmp = 0;
  int    n_err = 0;

  // Expected {rst_n_out, reset_done, busy, seq_state} after edge e, first FSM-active edge a.
  function automatic logic [7:0] model(int e, int a, logic [3:0] en, int n, int min_a, int dly);
    logic [3:0] o;
    logic       d;
    logic [1:0] st;
    o = 4'b0000;
    for (int k = 0; k < n; k++) begin
      if (en[k] && (e >= a + min_a + k * dly)) o[k] = 1'b1;
    end
    d  = (e >= a + min_a - 1 + n * dly);
    st = d ? 2'd2 : ((e >= a + min_a - 1) ? 2'd1 : 2'd0);
    return {o, d, ~d, st};
  endfunction

  task automatic push(string tag, int e, bit corner, logic [7:0] exp);
    item_t it;
    it.edge_n = e;
    it.corner = corner;
    it.exp    = exp;
    exp_q.push_back(it);
    tag_q.push_back(tag);
  endtask

  task automatic step();
    @(posedge clk);
    ecount = ecount + 1;
    #1;
  endtask

  task automatic run_queue();
    item_t      it;
    string      tag;
    logic [7:0] obs;
    int         guard;
    while (exp_q.size() > 0) begin
      it    = exp_q.pop_front();
      tag   = tag_q.pop_front();
      guard = 0;
      while ((ecount < it.edge_n) && (guard < 2000)) begin
        step();
        guard++;
      end
      obs = it.corner ? {3'b000, c_out, c_done, c_busy, c_state}
                      : {rst_n_out, reset_done, busy, seq_state};
      n_cmp++;
      assert ((obs === it.exp) && (ecount == it.edge_n)) else begin
        n_err++;
        $error("FAIL %s: observed %b at edge %0d, expected %b at edge %0d",
               tag, obs, ecount, it.exp, it.edge_n);
      end
    end
  endtask

  task automatic push_seq(string tag, int base, int a, logic [3:0] en);
    int pts [10] = '{4, 12, 13, 28, 29, 45, 60, 61, 75, 76};
    foreach (pts[i]) begin
      push($sformatf("%s_E%0d", tag, pts[i]), base + pts[i], 1'b0,
           model(base + pts[i], a, en, N, MIN, DLY));
    end
  endtask

  initial begin
    int base, a, f, g, a2;
    rst_n = 1'b0; soft_rst_req = 1'b0; domain_en = 4'hF;
    c_rst_n = 1'b0; c_soft = 1'b0; c_en = 1'b1;
    step(); step(); step();
    push("reset_state", ecount, 1'b0, 8'b0000_0100);
    push("corner_reset_state", ecount, 1'b1, 8'b0000_0100);
    run_queue();

    // Power-up sequence, all domains enabled.
    rst_n = 1'b1;
    base = ecount;
    a = base + SYN + 1;
    push_seq("pwrup", base, a, 4'hF);
    run_queue();
    domain_en = 4'h0;
    push("done_hold_en_change", base + 90, 1'b0, model(base + 90, a, 4'hF, N, MIN, DLY));
    run_queue();

    // Soft reset asserted in DONE for three sampled edges.
    soft_rst_req = 1'b1;
    f = ecount + 1;
    g = f + 3;
    push("soft_F", f, 1'b0, model(f, g, 4'hF, N, MIN, DLY));
    push("soft_F2", f + 2, 1'b0, model(f + 2, g, 4'hF, N, MIN, DLY));
    run_queue();
    soft_rst_req = 1'b0;
    domain_en = 4'hF;
    push("soft_G7", g + 7, 1'b0, model(g + 7, g, 4'hF, N, MIN, DLY));
    push("soft_G8", g + 8, 1'b0, model(g + 8, g, 4'hF, N, MIN, DLY));
    push("soft_G23", g + 23, 1'b0, model(g + 23, g, 4'hF, N, MIN, DLY));
    run_queue();

    // Soft request on domain 1's release edge.
    soft_rst_req = 1'b1;
    a2 = g + 25;
    push("simul_G24", g + 24, 1'b0, model(g + 24, a2, 4'hF, N, MIN, DLY));
    run_queue();
    soft_rst_req = 1'b0;
    push("simul_hold_A7", a2 + 7, 1'b0, model(a2 + 7, a2, 4'hF, N, MIN, DLY));
    push("simul_rel_A8", a2 + 8, 1'b0, model(a2 + 8, a2, 4'hF, N, MIN, DLY));
    push("simul_idx2_A45", a2 + 45, 1'b0, model(a2 + 45, a2, 4'hF, N, MIN, DLY));
    run_queue();

    // Asynchronous assert between edges while idx=2.
    #3;
    rst_n = 1'b0;
    #1;
    push("async_assert", ecount, 1'b0, 8'b0000_0100);
    run_queue();
    #2;
    rst_n = 1'b1;
    base = ecount;
    a = base + SYN + 1;
    push_seq("rerelease", base, a, 4'hF);
    run_queue();

    // Masked domain 2.
    rst_n = 1'b0;
    #1;
    domain_en = 4'b1011;
    step(); step();
    push("mask_reset", ecount, 1'b0, 8'b0000_0100);
    run_queue();
    rst_n = 1'b1;
    base = ecount;
    a = base + SYN + 1;
    push_seq("mask", base, a, 4'b1011);
    run_queue();

    // Corner parameters.
    c_rst_n = 1'b1;
    base = ecount;
    a = base + 2 + 1;
    for (int k = 1; k <= 6; k++) begin
      push($sformatf("corner_E%0d", k), base + k, 1'b1, model(base + k, a, 4'b0001, 1, 1, 1));
    end
    run_queue();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
